// File: rtl/iter_ctrl_fsm_pkg.sv
// Shared encodings for the iteration sequencer and the VNU3 write FSM it drives.
// Busy constants are common to both sides of the iter_rqst/upd_busy handshake.
package iter_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_REQ     = 3'b001,
    ST_UPDATE  = 3'b010,
    ST_RELEASE = 3'b011,
    ST_CHECK   = 3'b100,
    ST_TERM    = 3'b101,
    ST_DONE    = 3'b110
  } state_e;

  localparam logic [1:0] BUSY_IDLE = 2'b00;
  localparam logic [1:0] BUSY_UPD  = 2'b01;
  localparam logic [1:0] BUSY_FIN  = 2'b10;

  // States that wait on a busy transition and are therefore guarded by the timer
  function automatic logic is_timed(input state_e st);
    logic res;
    case (st)
      ST_REQ, ST_UPDATE, ST_RELEASE, ST_TERM: res = 1'b1;
      default:                                res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/iter_ctrl_fsm_chk.sv
// Protocol checker for the iter_rqst / iter_termination pair and the done pulse.
// Instantiated alongside iter_ctrl_fsm in simulation environments.
module iter_ctrl_fsm_chk (
  input logic write_clk,
  input logic rstn,
  input logic iter_rqst,
  input logic iter_termination,
  input logic decode_busy,
  input logic decode_done
);

  a_rqst_term_excl: assert property (@(posedge write_clk) disable iff (!rstn)
    !(iter_rqst && iter_termination));

  a_done_single: assert property (@(posedge write_clk) disable iff (!rstn)
    decode_done |=> !decode_done);

  a_rqst_busy: assert property (@(posedge write_clk) disable iff (!rstn)
    (iter_rqst || iter_termination) |-> decode_busy);

endmodule

// File: rtl/iter_ctrl_fsm_timeout.sv
// Handshake watchdog: counts while enabled, clears on request, saturates at ACK_TIMEOUT-1.
// hit is taken straight from the register so it never loops back into the FSM combinationally.
module hs_timeout_cnt #(
  parameter int ACK_TIMEOUT = 256
) (
  input  logic write_clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  logic [TMR_W-1:0] tmr_r;

  // Saturating timer; a clear takes priority over counting
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      tmr_r <= {TMR_W{1'b0}};
    end else if (clear) begin
      tmr_r <= {TMR_W{1'b0}};
    end else if (enable && (tmr_r != TMR_LAST)) begin
      tmr_r <= tmr_r + TMR_W'(1);
    end else begin
      tmr_r <= tmr_r;
    end
  end

  assign hit = (tmr_r == TMR_LAST);

endmodule

// File: rtl/iter_ctrl_fsm.sv
// Decoding-iteration sequencer in front of the VNU3 write FSM: issues iter_rqst/iter_termination,
// follows the busy[1:0] handshake and stops on zero syndrome, MAX_ITER, abort or handshake timeout.
module iter_ctrl_fsm
  import iter_ctrl_fsm_pkg::*;
#(
  parameter int MAX_ITER    = 10,
  parameter int ITER_W      = $clog2(MAX_ITER + 1),
  parameter int ACK_TIMEOUT = 256
) (
  input  logic              write_clk,
  input  logic              rstn,
  input  logic              decode_start,
  input  logic              abort,
  input  logic              syndrome_valid,
  input  logic              syndrome_zero,
  input  logic [1:0]        upd_busy,
  output logic              iter_rqst,
  output logic              iter_termination,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              decode_busy,
  output logic              decode_done,
  output logic              decode_success,
  output logic              timeout_err
);

  localparam logic [ITER_W-1:0] CNT_MAX = ITER_W'(MAX_ITER);

  state_e            state_r;
  state_e            state_nxt_s;
  logic              idle_seen_r;
  logic              tmo_hit_s;
  logic              tmr_clear_s;
  logic              tmr_en_s;
  logic              start_acc_s;
  logic              cnt_inc_s;
  logic              succ_set_s;
  logic              tmo_set_s;
  logic [ITER_W-1:0] iter_cnt_r;
  logic              iter_rqst_r;
  logic              iter_term_r;
  logic              decode_busy_r;
  logic              decode_done_r;
  logic              decode_success_r;
  logic              timeout_err_r;

  assign tmr_clear_s = (state_nxt_s != state_r);
  assign tmr_en_s    = is_timed(state_r);

  hs_timeout_cnt #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_hs_timeout_cnt (
    .write_clk(write_clk),
    .rstn     (rstn),
    .clear    (tmr_clear_s),
    .enable   (tmr_en_s),
    .hit      (tmo_hit_s)
  );

  // State register
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and one-cycle event strobes for the datapath
  always_comb begin
    state_nxt_s = state_r;
    start_acc_s = 1'b0;
    cnt_inc_s   = 1'b0;
    succ_set_s  = 1'b0;
    tmo_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (decode_start) begin
          state_nxt_s = ST_REQ;
          start_acc_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (abort) begin
          state_nxt_s = ST_TERM;
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_DONE;
          tmo_set_s   = 1'b1;
        end else if (upd_busy == BUSY_UPD) begin
          state_nxt_s = ST_UPDATE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_UPDATE: begin
        if (abort) begin
          state_nxt_s = ST_TERM;
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_DONE;
          tmo_set_s   = 1'b1;
        end else if (upd_busy == BUSY_FIN) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_UPDATE;
        end
      end
      ST_RELEASE: begin
        if (abort) begin
          state_nxt_s = ST_TERM;
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_DONE;
          tmo_set_s   = 1'b1;
        end else if (upd_busy == BUSY_IDLE) begin
          state_nxt_s = ST_CHECK;
          cnt_inc_s   = 1'b1;
        end else begin
          state_nxt_s = ST_RELEASE;
        end
      end
      ST_CHECK: begin
        // Abort outranks a simultaneous syndrome; a zero syndrome outranks MAX_ITER
        if (abort) begin
          state_nxt_s = ST_TERM;
        end else if (syndrome_valid && syndrome_zero) begin
          state_nxt_s = ST_TERM;
          succ_set_s  = 1'b1;
        end else if (syndrome_valid && (iter_cnt_r == CNT_MAX)) begin
          state_nxt_s = ST_TERM;
        end else if (syndrome_valid) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_CHECK;
        end
      end
      ST_TERM: begin
        if (tmo_hit_s) begin
          state_nxt_s = ST_DONE;
          tmo_set_s   = 1'b1;
        end else if ((upd_busy == BUSY_IDLE) && idle_seen_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_TERM;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Counters, sticky flags and the registered Moore output decode
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      idle_seen_r      <= 1'b0;
      iter_cnt_r       <= {ITER_W{1'b0}};
      decode_success_r <= 1'b0;
      timeout_err_r    <= 1'b0;
      iter_rqst_r      <= 1'b0;
      iter_term_r      <= 1'b0;
      decode_busy_r    <= 1'b0;
      decode_done_r    <= 1'b0;
    end else begin
      idle_seen_r <= (state_r == ST_TERM) && (upd_busy == BUSY_IDLE) && (state_nxt_s == ST_TERM);

      if (start_acc_s) begin
        iter_cnt_r <= {ITER_W{1'b0}};
      end else if (cnt_inc_s && (iter_cnt_r != CNT_MAX)) begin
        iter_cnt_r <= iter_cnt_r + ITER_W'(1);
      end else begin
        iter_cnt_r <= iter_cnt_r;
      end

      if (start_acc_s) begin
        decode_success_r <= 1'b0;
      end else if (succ_set_s) begin
        decode_success_r <= 1'b1;
      end else begin
        decode_success_r <= decode_success_r;
      end

      if (start_acc_s) begin
        timeout_err_r <= 1'b0;
      end else if (tmo_set_s) begin
        timeout_err_r <= 1'b1;
      end else begin
        timeout_err_r <= timeout_err_r;
      end

      iter_rqst_r   <= (state_nxt_s == ST_REQ) || (state_nxt_s == ST_UPDATE);
      iter_term_r   <= (state_nxt_s == ST_TERM);
      decode_busy_r <= (state_nxt_s != ST_IDLE);
      decode_done_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign iter_rqst        = iter_rqst_r;
  assign iter_termination = iter_term_r;
  assign iter_cnt         = iter_cnt_r;
  assign decode_busy      = decode_busy_r;
  assign decode_done      = decode_done_r;
  assign decode_success   = decode_success_r;
  assign timeout_err      = timeout_err_r;

endmodule
